// File: rtl/mine_placer.sv
// Mine map builder: draws 6-bit cells from the lfsr, skips duplicates and excluded cells, and
// strobes ld_mm once NUM_MINES are placed. Define SAFE_ZONE_EN to exclude safe_pos's 3x3 block.
module mine_placer #(
  parameter int unsigned NUM_MINES       = 10,
  parameter int unsigned SHIFTS_PER_DRAW = 6,
  parameter int unsigned MAX_TRIES       = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [5:0]  safe_pos,
  input  logic [5:0]  rnd_in,
  output logic        rnd_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ld_mm,
  output logic [63:0] mine_map
);

  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
  localparam int unsigned ShiftW = $clog2(SHIFTS_PER_DRAW + 1);
`ifdef SAFE_ZONE_EN
  localparam int unsigned MaxMines = 55;
`else
  localparam int unsigned MaxMines = 63;
`endif

  if ((NUM_MINES < 1) || (NUM_MINES > MaxMines)) begin : gen_bad_cfg
    $error("mine_placer: NUM_MINES out of legal range");
  end

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StClear  = 3'd1;
  localparam logic [2:0] StDraw   = 3'd2;
  localparam logic [2:0] StCheck  = 3'd3;
  localparam logic [2:0] StFinish = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [63:0]       map_q, map_d;
  logic [5:0]        count_q, count_d;
  logic [TriesW-1:0] tries_q, tries_d;
  logic [ShiftW-1:0] shift_q, shift_d;
  logic [5:0]        safe_q, safe_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [63:0]       excl_mask;
  logic [5:0]        count_inc;
  logic [TriesW-1:0] tries_inc;
  logic              accept;

  always_comb begin
    excl_mask = '0;
`ifdef SAFE_ZONE_EN
    begin
      int yy;
      int xx;
      yy = 0;
      xx = 0;
      for (int dy = -1; dy <= 1; dy++) begin
        for (int dx = -1; dx <= 1; dx++) begin
          yy = int'({1'b0, safe_q[5:3]}) + dy;
          xx = int'({1'b0, safe_q[2:0]}) + dx;
          // Neighbours falling off the board are simply dropped.
          if ((yy >= 0) && (yy < 8) && (xx >= 0) && (xx < 8)) begin
            excl_mask[6'(yy * 8 + xx)] = 1'b1;
          end
        end
      end
    end
`else
    excl_mask[safe_q] = 1'b1;
`endif
  end

  assign count_inc = count_q + 6'd1;
  assign tries_inc = tries_q + 1'b1;
  assign accept    = !map_q[rnd_in] && !excl_mask[rnd_in];

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    count_d = count_q;
    tries_d = tries_q;
    shift_d = shift_q;
    safe_d  = safe_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClear;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StClear: begin
        map_d   = '0;
        count_d = '0;
        tries_d = '0;
        shift_d = '0;
        safe_d  = safe_pos;
        state_d = StDraw;
      end
      StDraw: begin
        if (shift_q == ShiftW'(SHIFTS_PER_DRAW - 1)) begin
          shift_d = '0;
          state_d = StCheck;
        end else begin
          shift_d = shift_q + 1'b1;
        end
      end
      StCheck: begin
        tries_d = tries_inc;
        if (accept) begin
          map_d[rnd_in] = 1'b1;
          count_d       = count_inc;
        end
        if (accept && (count_inc == 6'(NUM_MINES))) begin
          state_d = StFinish;
        end else if (tries_inc == TriesW'(MAX_TRIES)) begin
          state_d = StFinish;
          err_d   = 1'b1;
        end else begin
          state_d = StDraw;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      map_q   <= '0;
      count_q <= '0;
      tries_q <= '0;
      shift_q <= '0;
      safe_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      count_q <= count_d;
      tries_q <= tries_d;
      shift_q <= shift_d;
      safe_q  <= safe_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rnd_en   = (state_q == StDraw);
  assign busy     = (state_q != StIdle);
  assign ld_mm    = (state_q == StFinish) && !err_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mine_map = map_q;

endmodule
